// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and constants for the FIFO write arbiter:
//               FSM state encoding, beat counter width, default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    // Arbiter FSM state encoding
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Width of the per-burst beat counter (saturates at all-ones)
    localparam int BEAT_W = 4;

    // Default parameter values for the arbiter top
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_BURST_MAX  = 4;

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin search. Returns the first set bit
//               of i_req starting at i_last+1 and wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_next
);

    // Scan candidates from farthest to nearest so the nearest hit wins
    always_comb begin
        o_found = 1'b0;
        o_next  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (i_req[IDX_W'((int'(i_last) + k) % NUM_REQ)]) begin
                o_found = 1'b1;
                o_next  = IDX_W'((int'(i_last) + k) % NUM_REQ);
            end
        end
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter granting bursts from NUM_REQ requesters
//               into a single FIFO write port. Zero-latency data path,
//               burst ends on last, BURST_MAX beats or almost-full.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int BURST_MAX  = DEF_BURST_MAX
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [BEAT_W-1:0]             beat_count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t        r_state;
    logic [IDX_W-1:0]  r_grant_id;
    logic [IDX_W-1:0]  r_last_grant;
    logic [BEAT_W-1:0] r_beat_count;

    logic              w_found;
    logic [IDX_W-1:0]  w_next;
    logic              w_in_burst;
    logic              w_gnt_valid;
    logic              w_gnt_last;
    logic              w_xfer;
    logic              w_end_burst;
    logic [BEAT_W-1:0] w_beat_inc;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .i_req   (req_valid),
        .i_last  (r_last_grant),
        .o_found (w_found),
        .o_next  (w_next)
    );

    assign w_in_burst = (r_state == BURST);

    // Select the grantee's valid/last/data and drive its ready bit
    always_comb begin
        w_gnt_valid  = 1'b0;
        w_gnt_last   = 1'b0;
        req_ready    = '0;
        fifo_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == IDX_W'(i)) begin
                w_gnt_valid  = req_valid[i];
                w_gnt_last   = req_last[i];
                req_ready[i] = w_in_burst && !fifo_full;
                if (w_in_burst && !fifo_full && req_valid[i]) begin
                    fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // A beat moves only when the grantee is valid and the FIFO has room
    assign w_xfer      = w_in_burst && w_gnt_valid && !fifo_full;
    assign fifo_wr_en  = w_xfer;
    assign w_beat_inc  = (r_beat_count == {BEAT_W{1'b1}}) ? r_beat_count
                                                           : r_beat_count + BEAT_W'(1);
    assign w_end_burst = w_xfer && (w_gnt_last
                                    || (w_beat_inc == BEAT_W'(BURST_MAX))
                                    || fifo_almost_full);

    assign grant_id   = r_grant_id;
    assign beat_count = r_beat_count;
    assign busy       = w_in_burst;

    // Arbiter FSM: grant in IDLE, count and terminate beats in BURST
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant_id   <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_beat_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found && !fifo_full) begin
                        r_grant_id   <= w_next;
                        r_beat_count <= '0;
                        r_state      <= BURST;
                    end
                end
                BURST: begin
                    if (!w_gnt_valid) begin
                        // Grantee dropped out: release without a transfer
                        r_state      <= IDLE;
                        r_last_grant <= r_grant_id;
                    end else if (w_xfer) begin
                        r_beat_count <= w_beat_inc;
                        if (w_end_burst) begin
                            r_state      <= IDLE;
                            r_last_grant <= r_grant_id;
                        end
                    end
                    // FIFO full with a valid grantee: hold everything
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed self-checking bench for fifo_wr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0] req_last;
    logic [NR-1:0] req_ready;
    logic          fifo_full;
    logic          fifo_almost_full;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_data_in;
    logic [1:0]    grant_id;
    logic          busy;
    logic [3:0]    beat_count;

    int n_checks;
    int n_fail;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .BURST_MAX  (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_data_in     (fifo_data_in),
        .grant_id         (grant_id),
        .busy             (busy),
        .beat_count       (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Check all outputs at the falling edge, then move past the next rising edge
    task automatic cyc(input string tag, input logic e_busy, input logic [1:0] e_gid,
                       input logic [3:0] e_beat, input logic e_wr,
                       input logic [7:0] e_data, input logic [3:0] e_rdy);
        @(negedge clk);
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".gid"},  32'(grant_id), 32'(e_gid));
        chk({tag, ".beat"}, 32'(beat_count), 32'(e_beat));
        chk({tag, ".wr"},   32'(fifo_wr_en), 32'(e_wr));
        chk({tag, ".data"}, 32'(fifo_data_in), 32'(e_data));
        chk({tag, ".rdy"},  32'(req_ready), 32'(e_rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid        = '0;
        req_last         = '0;
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;
        rst              = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        fifo_almost_full = 1'b0;
        rst = 1'b1;

        // Reset state while rst held
        @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.gid",  32'(grant_id), 32'd0);
        chk("rst.beat", 32'(beat_count), 32'd0);
        chk("rst.wr",   32'(fifo_wr_en), 32'd0);
        chk("rst.rdy",  32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Requesters 0 and 2 always valid: grants 0,2,0,2, four beats each
        req_valid = 4'b0101;
        for (int b = 0; b < 4; b++) begin
            logic [1:0] g;
            g = (b % 2 == 0) ? 2'd0 : 2'd2;
            cyc("rr.idle", 1'b0, (b == 0) ? 2'd0 : ((b % 2 == 0) ? 2'd2 : 2'd0),
                (b == 0) ? 4'd0 : 4'd4, 1'b0, 8'h00, 4'b0000);
            for (int j = 0; j < 4; j++) begin
                cyc("rr.beat", 1'b1, g, 4'(j), 1'b1, 8'h10 + 8'(g), 4'b0001 << g);
            end
        end
        req_valid = '0;
        cyc("rr.end", 1'b0, 2'd2, 4'd4, 1'b0, 8'h00, 4'b0000);

        // Requester 1: three beats A1..A3, last on A3
        do_reset();
        req_valid = 4'b0010;
        req_data  = {8'h13, 8'h12, 8'hA1, 8'h10};
        cyc("last.idle", 1'b0, 2'd0, 4'd0, 1'b0, 8'h00, 4'b0000);
        cyc("last.b0", 1'b1, 2'd1, 4'd0, 1'b1, 8'hA1, 4'b0010);
        req_data  = {8'h13, 8'h12, 8'hA2, 8'h10};
        cyc("last.b1", 1'b1, 2'd1, 4'd1, 1'b1, 8'hA2, 4'b0010);
        req_data  = {8'h13, 8'h12, 8'hA3, 8'h10};
        req_last  = 4'b0010;
        cyc("last.b2", 1'b1, 2'd1, 4'd2, 1'b1, 8'hA3, 4'b0010);
        req_last  = '0;
        req_valid = '0;
        cyc("last.idle2", 1'b0, 2'd1, 4'd3, 1'b0, 8'h00, 4'b0000);

        // FIFO full stall for 5 cycles after beat 2
        do_reset();
        req_valid = 4'b0001;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h55};
        cyc("full.idle", 1'b0, 2'd0, 4'd0, 1'b0, 8'h00, 4'b0000);
        cyc("full.b0", 1'b1, 2'd0, 4'd0, 1'b1, 8'h55, 4'b0001);
        cyc("full.b1", 1'b1, 2'd0, 4'd1, 1'b1, 8'h55, 4'b0001);
        fifo_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            cyc("full.stall", 1'b1, 2'd0, 4'd2, 1'b0, 8'h00, 4'b0000);
        end
        fifo_full = 1'b0;
        cyc("full.b2", 1'b1, 2'd0, 4'd2, 1'b1, 8'h55, 4'b0001);
        cyc("full.b3", 1'b1, 2'd0, 4'd3, 1'b1, 8'h55, 4'b0001);
        req_valid = '0;
        cyc("full.idle2", 1'b0, 2'd0, 4'd4, 1'b0, 8'h00, 4'b0000);

        // Almost-full on the first beat: single write then IDLE
        do_reset();
        req_valid = 4'b0001;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h66};
        fifo_almost_full = 1'b1;
        cyc("afull.idle", 1'b0, 2'd0, 4'd0, 1'b0, 8'h00, 4'b0000);
        cyc("afull.b0", 1'b1, 2'd0, 4'd0, 1'b1, 8'h66, 4'b0001);
        cyc("afull.idle2", 1'b0, 2'd0, 4'd1, 1'b0, 8'h00, 4'b0000);
        fifo_almost_full = 1'b0;

        // Wrap: grant 3 then all valid -> grant 0
        do_reset();
        req_data  = {8'h33, 8'h22, 8'h11, 8'h00};
        req_valid = 4'b1000;
        req_last  = 4'b1000;
        cyc("wrap.idle", 1'b0, 2'd0, 4'd0, 1'b0, 8'h00, 4'b0000);
        cyc("wrap.b3", 1'b1, 2'd3, 4'd0, 1'b1, 8'h33, 4'b1000);
        req_valid = 4'b1111;
        req_last  = 4'b0000;
        cyc("wrap.idle2", 1'b0, 2'd3, 4'd1, 1'b0, 8'h00, 4'b0000);
        cyc("wrap.b0", 1'b1, 2'd0, 4'd0, 1'b1, 8'h00, 4'b0001);

        // Reset during beat 2 of a burst from requester 2
        do_reset();
        req_valid = 4'b0100;
        cyc("mrst.idle", 1'b0, 2'd0, 4'd0, 1'b0, 8'h00, 4'b0000);
        cyc("mrst.b0", 1'b1, 2'd2, 4'd0, 1'b1, 8'h22, 4'b0100);
        cyc("mrst.b1", 1'b1, 2'd2, 4'd1, 1'b1, 8'h22, 4'b0100);
        rst = 1'b1;
        #1;
        chk("mrst.busy", 32'(busy), 32'd0);
        chk("mrst.gid",  32'(grant_id), 32'd0);
        chk("mrst.beat", 32'(beat_count), 32'd0);
        chk("mrst.wr",   32'(fifo_wr_en), 32'd0);
        chk("mrst.data", 32'(fifo_data_in), 32'd0);
        chk("mrst.rdy",  32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 4'b1111;
        cyc("mrst.idle2", 1'b0, 2'd0, 4'd0, 1'b0, 8'h00, 4'b0000);
        cyc("mrst.g0", 1'b1, 2'd0, 4'd0, 1'b1, 8'h00, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
